// File: rtl/cmul_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cmul_rr_arbiter_pkg
// Shared definitions for the round-robin complex-multiplier arbiter:
//   - PART_LEN_DEFAULT : default width of one real/imag part
//   - id_width()       : requester-index width for a given requester count
//   - cplx_re/cplx_im  : field select of a packed complex word {real, imag}
//   - cplx_pack        : build a packed complex word from its two parts
// The complex helpers take the part width as an argument and operate on a
// 64-bit carrier, so they serve any part width up to 32 bits.
// -----------------------------------------------------------------------------
package cmul_rr_arbiter_pkg;

    localparam int PART_LEN_DEFAULT = 8;

    // Index width for n requesters; never below one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [63:0] part_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Real part lives in the upper half of the packed word.
    function automatic logic [31:0] cplx_re(input logic [63:0] c, input int w);
        return 32'((c >> w) & part_mask(w));
    endfunction

    function automatic logic [31:0] cplx_im(input logic [63:0] c, input int w);
        return 32'(c & part_mask(w));
    endfunction

    function automatic logic [63:0] cplx_pack(input logic [31:0] re,
                                              input logic [31:0] im,
                                              input int          w);
        return ((64'(re) & part_mask(w)) << w) | (64'(im) & part_mask(w));
    endfunction

endpackage

// File: rtl/cmul_rr_arbiter_mul_c.sv
// -----------------------------------------------------------------------------
// cmul_rr_arbiter_mul_c
// Combinational complex multiplier (MUL_C):
//   real = ra*rb - ia*ib, imag = ra*ib + rb*ia, signed, each part wrapped
//   to its low PART_LEN bits.
//   a_i, b_i : packed operands {real, imag}
//   p_o      : packed product  {real, imag}
// -----------------------------------------------------------------------------
module cmul_rr_arbiter_mul_c
    import cmul_rr_arbiter_pkg::*;
#(
    parameter int PART_LEN = PART_LEN_DEFAULT
) (
    input  logic [2*PART_LEN-1:0] a_i,
    input  logic [2*PART_LEN-1:0] b_i,
    output logic [2*PART_LEN-1:0] p_o
);

    localparam int CW = 2 * PART_LEN;

    logic signed [PART_LEN-1:0] ra, ia, rb, ib;
    logic signed [PART_LEN-1:0] re, im;

    always_comb begin
        ra = PART_LEN'(cplx_re(64'(a_i), PART_LEN));
        ia = PART_LEN'(cplx_im(64'(a_i), PART_LEN));
        rb = PART_LEN'(cplx_re(64'(b_i), PART_LEN));
        ib = PART_LEN'(cplx_im(64'(b_i), PART_LEN));
        // Evaluated in a PART_LEN-wide context: only the low PART_LEN bits of
        // each product survive, which is exactly the required wrap-around.
        re = ra * rb - ia * ib;
        im = ra * ib + rb * ia;
        p_o = CW'(cplx_pack(32'(re), 32'(im), PART_LEN));
    end

endmodule

// File: rtl/cmul_rr_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// cmul_rr_arbiter_rr_grant
// Combinational round-robin search: the first asserted request at or after
// ptr (wrapping modulo NREQ) wins.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester (0 when no request)
//   any_o   : at least one request is asserted
// -----------------------------------------------------------------------------
module cmul_rr_arbiter_rr_grant
    import cmul_rr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/cmul_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cmul_rr_arbiter
// Shares one complex multiplier among NREQ valid/ready requesters with a
// round-robin grant. At most one operation issues per cycle; the product is
// registered together with the requester index in a one-entry output stage
// with valid/ready backpressure.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept (combinational)
//   req_a/req_b: packed operands, requester i at [i*2*PART_LEN +: 2*PART_LEN]
//   out_valid  : result register holds a product
//   out_ready  : consumer accepts the result
//   out_data   : product {real, imag}
//   out_id     : requester that produced out_data
//   issued_cnt : number of accepted operations, wrapping
// -----------------------------------------------------------------------------
module cmul_rr_arbiter
    import cmul_rr_arbiter_pkg::*;
#(
    parameter int PART_LEN = PART_LEN_DEFAULT,
    parameter int NREQ     = 4,
    parameter int ID_W     = id_width(NREQ),
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*2*PART_LEN-1:0] req_a,
    input  logic [NREQ*2*PART_LEN-1:0] req_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*PART_LEN-1:0]      out_data,
    output logic [ID_W-1:0]            out_id,
    output logic [CNT_W-1:0]           issued_cnt
);

    localparam int CW = 2 * PART_LEN;

    logic              out_valid_q, out_valid_d;
    logic [CW-1:0]     out_data_q,  out_data_d;
    logic [ID_W-1:0]   out_id_q,    out_id_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic              issue_en;
    logic              handshake;
    logic [CW-1:0]     op_a, op_b, product;

    cmul_rr_arbiter_rr_grant #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_grant (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // The output register can take a new result when empty or being drained.
    assign issue_en  = !out_valid_q || out_ready;
    assign req_ready = (rst || !issue_en || !grant_any) ? '0 : grant;
    assign handshake = |(req_valid & req_ready);

    assign op_a = req_a[grant_idx*CW +: CW];
    assign op_b = req_b[grant_idx*CW +: CW];

    cmul_rr_arbiter_mul_c #(
        .PART_LEN (PART_LEN)
    ) u_mul_c (
        .a_i (op_a),
        .b_i (op_b),
        .p_o (product)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (handshake) begin
            // Covers simultaneous drain and issue: the new result replaces
            // the old one and valid stays high.
            out_valid_d = 1'b1;
            out_data_d  = product;
            out_id_d    = grant_idx;
            cnt_d       = cnt_q + 1'b1;
            rr_ptr_d    = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its next-state value from before this edge.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_cmul_rr_arbiter.sv
module tb_cmul_rr_arbiter;

    localparam int PART_LEN = 8;
    localparam int NREQ     = 4;
    localparam int ID_W     = 2;
    localparam int CNT_W    = 16;
    localparam int CW       = 2 * PART_LEN;

    typedef struct packed {
        logic [CW-1:0]   data;
        logic [ID_W-1:0] id;
    } result_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*CW-1:0]    req_a;
    logic [NREQ*CW-1:0]    req_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [CW-1:0]         out_data;
    logic [ID_W-1:0]       out_id;
    logic [CNT_W-1:0]      issued_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    result_t          sb[$];
    logic             m_valid = 1'b0;
    int               m_ptr   = 0;
    logic [CNT_W-1:0] m_cnt   = '0;

    always #5 clk = ~clk;

    cmul_rr_arbiter #(
        .PART_LEN (PART_LEN),
        .NREQ     (NREQ),
        .ID_W     (ID_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .issued_cnt (issued_cnt)
    );

    function automatic logic [CW-1:0] cmul_ref(input logic [CW-1:0] a, input logic [CW-1:0] b);
        int ra, ia, rb, ib, re, im;
        logic [7:0] re8, im8;
        ra = int'($signed(a[15:8]));
        ia = int'($signed(a[7:0]));
        rb = int'($signed(b[15:8]));
        ib = int'($signed(b[7:0]));
        re = ra * rb - ia * ib;
        im = ra * ib + rb * ia;
        re8 = re[7:0];
        im8 = im[7:0];
        return {re8, im8};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [CW-1:0] a, input logic [CW-1:0] b);
        req_valid[i]       = v;
        req_a[i*CW +: CW]  = a;
        req_b[i*CW +: CW]  = b;
    endtask

    // One clock cycle: inputs are already driven (at the falling edge).
    // Compares DUT outputs against the model, then advances the model across
    // the rising edge and returns at the next falling edge.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        logic            issue_en;
        logic            hs;
        int              g;
        result_t         r;
        #1;
        issue_en = !m_valid || out_ready;
        exp_rdy  = '0;
        g        = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[j]) g = j;
        end
        hs = !rst && issue_en && (g >= 0);
        if (hs) exp_rdy[g] = 1'b1;

        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL step_req_ready: got %b expected %b at %0t", req_ready, exp_rdy, $time);
        end
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL step_out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
        end
        if (m_valid && sb.size() > 0) begin
            checks++;
            if (out_data !== sb[0].data || out_id !== sb[0].id) begin
                errors++;
                $display("FAIL step_result: got data=%h id=%0d expected data=%h id=%0d at %0t",
                         out_data, out_id, sb[0].data, sb[0].id, $time);
            end
        end
        checks++;
        if (issued_cnt !== m_cnt) begin
            errors++;
            $display("FAIL step_issued_cnt: got %0d expected %0d at %0t", issued_cnt, m_cnt, $time);
        end

        if (hs) begin
            r.data = cmul_ref(req_a[g*CW +: CW], req_b[g*CW +: CW]);
            r.id   = ID_W'(g);
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
            m_cnt   = '0;
        end else begin
            if (m_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            if (hs) begin
                sb.push_back(r);
                m_valid = 1'b1;
                m_ptr   = (g + 1) % NREQ;
                m_cnt   = m_cnt + 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        clear_reqs();
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || issued_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h id=%0d cnt=%0d expected all zero",
                     out_valid, out_data, out_id, issued_cnt);
        end
    endtask

    task automatic test_single_op();
        out_ready = 1'b1;
        set_req(1, 1'b1, 16'h0302, 16'h0104);
        step();
        clear_reqs();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hFB0E || out_id !== 2'd1 || issued_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_op: got valid=%b data=%h id=%0d cnt=%0d expected 1 FB0E 1 1",
                     out_valid, out_data, out_id, issued_cnt);
        end
        step();
    endtask

    task automatic test_wrap();
        set_req(0, 1'b1, 16'h6400, 16'h0200);
        step();
        clear_reqs();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hC800 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL wrap: got valid=%b data=%h id=%0d expected 1 C800 0", out_valid, out_data, out_id);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [ID_W-1:0] exp_ids [5];
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, {8'(i + 1), 8'(i)}, {8'(i), 8'(3 - i)});
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_id !== exp_ids[k]) begin
                errors++;
                $display("FAIL round_robin[%0d]: got valid=%b id=%0d expected 1 %0d",
                         k, out_valid, out_id, exp_ids[k]);
            end
        end
        clear_reqs();
        step();
    endtask

    task automatic test_backpressure();
        logic [CW-1:0]    held_data;
        logic [ID_W-1:0]  held_id;
        logic [CNT_W-1:0] cnt_before;
        out_ready = 1'b1;
        set_req(0, 1'b1, 16'h0505, 16'h0203);
        set_req(2, 1'b1, 16'h0111, 16'h0F02);
        step();
        req_valid[2] = 1'b0;
        out_ready    = 1'b0;
        held_data    = out_data;
        held_id      = out_id;
        cnt_before   = issued_cnt;
        checks++;
        if (out_id !== 2'd2) begin
            errors++;
            $display("FAIL bp_first_id: got %0d expected 2", out_id);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL bp_req_ready[%0d]: got %b expected 0000", k, req_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_id !== held_id) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h id=%0d expected 1 %h %0d",
                         k, out_valid, out_data, out_id, held_data, held_id);
            end
        end
        out_ready = 1'b1;
        step();
        clear_reqs();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== cmul_ref(16'h0505, 16'h0203) ||
            issued_cnt !== cnt_before + 16'd1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b id=%0d data=%h cnt=%0d expected 1 0 %h %0d",
                     out_valid, out_id, out_data, issued_cnt, cmul_ref(16'h0505, 16'h0203), cnt_before + 16'd1);
        end
        step();
    endtask

    task automatic test_fairness_idle();
        out_ready = 1'b1;
        set_req(2, 1'b1, 16'h0201, 16'h0101);
        step();
        clear_reqs();
        step();
        step();
        set_req(0, 1'b1, 16'h0102, 16'h0304);
        set_req(3, 1'b1, 16'h0406, 16'h0101);
        step();
        req_valid[3] = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd3) begin
            errors++;
            $display("FAIL fairness_first: got valid=%b id=%0d expected 1 3", out_valid, out_id);
        end
        step();
        clear_reqs();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL fairness_second: got valid=%b id=%0d expected 1 0", out_valid, out_id);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_req(2, 1'b1, 16'h0707, 16'h0101);
        step();
        clear_reqs();
        set_req(1, 1'b1, 16'h0303, 16'h0202);
        set_req(3, 1'b1, 16'h0404, 16'h0101);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || issued_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: got valid=%b cnt=%0d expected 0 0", out_valid, issued_cnt);
        end
        out_ready = 1'b1;
        step();
        clear_reqs();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== cmul_ref(16'h0303, 16'h0202)) begin
            errors++;
            $display("FAIL reset_mid_first_grant: got valid=%b id=%0d data=%h expected 1 1 %h",
                     out_valid, out_id, out_data, cmul_ref(16'h0303, 16'h0202));
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*CW +: CW] = CW'($urandom);
                req_b[i*CW +: CW] = CW'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        clear_reqs();
        out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_fairness_idle();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
